// File: rtl/spi_link_ctrl_if.sv
// Handshake/data bundle between spi_link_ctrl, the tracker/status logic and the SPI slave top.
interface spi_link_ctrl_if;
    // Tracker / status side
    logic        track_valid;
    logic [9:0]  track_x;
    logic [8:0]  track_y;
    logic        status_req;
    logic [7:0]  status_byte;
    // MISO staging toward the SPI slave
    logic        frame_req;
    logic [9:0]  enemy_xdata;
    logic [8:0]  enemy_ydata;
    logic [12:0] miso_etc;
    // MOSI receive path and motor commands
    logic        mosi_valid;
    logic [7:0]  mosi_x;
    logic [6:0]  mosi_y;
    logic [16:0] mosi_etc;
    logic [7:0]  motor_x;
    logic [6:0]  motor_y;
    logic        motor_en;
    logic        motor_upd;
    logic        link_timeout;
    logic [7:0]  drop_cnt;

    // Controller side
    modport slave (
        input  track_valid, track_x, track_y, status_req, status_byte,
        input  frame_req, mosi_valid, mosi_x, mosi_y, mosi_etc,
        output enemy_xdata, enemy_ydata, miso_etc,
        output motor_x, motor_y, motor_en, motor_upd, link_timeout, drop_cnt
    );

    // Environment side (tracker, status source, SPI slave top)
    modport master (
        output track_valid, track_x, track_y, status_req, status_byte,
        output frame_req, mosi_valid, mosi_x, mosi_y, mosi_etc,
        input  enemy_xdata, enemy_ydata, miso_etc,
        input  motor_x, motor_y, motor_en, motor_upd, link_timeout, drop_cnt
    );
endinterface

// File: rtl/spi_link_ctrl.sv
// Frame scheduler for the SPI link: stages tracker/status/idle MISO frames with round-robin
// arbitration, commits them on frame_req, and drives motor commands under a link watchdog.
module spi_link_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 10_000_000,
    parameter logic [7:0]  X_CENTER    = 8'd128,
    parameter logic [6:0]  Y_CENTER    = 7'd64
) (
    input logic            clk,
    input logic            reset,
    spi_link_ctrl_if.slave bus
);
    localparam int unsigned XW    = 10;
    localparam int unsigned YW    = 9;
    localparam int unsigned ETC_W = 13;
    localparam int unsigned SEQ_W = 3;
    localparam int unsigned MXW   = 8;
    localparam int unsigned MYW   = 7;
    localparam int unsigned DRP_W = 8;
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC);
    localparam logic [DRP_W-1:0] DRP_MAX  = '1;
    localparam logic [1:0]       TAG_IDLE = 2'b00;
    localparam logic [1:0]       TAG_TRK  = 2'b01;
    localparam logic [1:0]       TAG_STS  = 2'b10;

    // Pending buffers
    logic             trk_pend_q, trk_pend_d;
    logic [XW-1:0]    trk_x_q, trk_x_d;
    logic [YW-1:0]    trk_y_q, trk_y_d;
    logic             sts_pend_q, sts_pend_d;
    logic [7:0]       sts_byte_q, sts_byte_d;
    logic             last_sts_q, last_sts_d;   // 1: last committed payload was status
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [XW-1:0]    sent_x_q, sent_x_d;       // coords of the last committed track frame
    logic [YW-1:0]    sent_y_q, sent_y_d;
    logic [DRP_W-1:0] drop_q, drop_d;

    // Staged MISO frame
    logic [XW-1:0]    enemy_x_q, enemy_x_d;
    logic [YW-1:0]    enemy_y_q, enemy_y_d;
    logic [ETC_W-1:0] etc_q, etc_d;

    // Motor path and watchdog
    logic [MXW-1:0]   motor_x_q, motor_x_d;
    logic [MYW-1:0]   motor_y_q, motor_y_d;
    logic             motor_en_q, motor_en_d;
    logic             motor_upd_q, motor_upd_d;
    logic             timeout_q, timeout_d;
    logic [WD_W-1:0]  wd_q, wd_d;

    logic commit_trk_c, commit_sts_c;
    logic trk_eff_c, sts_eff_c;
    logic [1:0] grant_c;
    logic unused_etc_c;

    // Only the enable bit of the received etc field is consumed here.
    assign unused_etc_c = ^bus.mosi_etc[15:0];

    // Commit, pending update, arbitration/staging and watchdog next-state.
    always_comb begin
        trk_pend_d  = trk_pend_q;
        trk_x_d     = trk_x_q;
        trk_y_d     = trk_y_q;
        sts_pend_d  = sts_pend_q;
        sts_byte_d  = sts_byte_q;
        last_sts_d  = last_sts_q;
        seq_d       = seq_q;
        sent_x_d    = sent_x_q;
        sent_y_d    = sent_y_q;
        drop_d      = drop_q;
        enemy_x_d   = sent_x_q;
        enemy_y_d   = sent_y_q;
        etc_d       = etc_q;
        grant_c     = TAG_IDLE;
        motor_x_d   = motor_x_q;
        motor_y_d   = motor_y_q;
        motor_en_d  = motor_en_q;
        motor_upd_d = 1'b0;
        timeout_d   = timeout_q;
        wd_d        = wd_q;

        // The staged tag decides which source a frame_req consumes.
        commit_trk_c = bus.frame_req && (etc_q[ETC_W-1 -: 2] == TAG_TRK);
        commit_sts_c = bus.frame_req && (etc_q[ETC_W-1 -: 2] == TAG_STS);
        trk_eff_c    = trk_pend_q && !commit_trk_c;
        sts_eff_c    = sts_pend_q && !commit_sts_c;

        if (bus.frame_req) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        if (commit_trk_c) begin
            last_sts_d = 1'b0;
            sent_x_d   = enemy_x_q;
            sent_y_d   = enemy_y_q;
        end
        if (commit_sts_c) begin
            last_sts_d = 1'b1;
        end

        // Arbitrate on post-commit pending state; new pulses are staged one cycle later.
        if (trk_eff_c && sts_eff_c) begin
            grant_c = last_sts_d ? TAG_TRK : TAG_STS;
        end else if (trk_eff_c) begin
            grant_c = TAG_TRK;
        end else if (sts_eff_c) begin
            grant_c = TAG_STS;
        end

        enemy_x_d = sent_x_d;
        enemy_y_d = sent_y_d;
        case (grant_c)
            TAG_TRK: begin
                enemy_x_d = trk_x_q;
                enemy_y_d = trk_y_q;
                etc_d     = {TAG_TRK, seq_d, 8'h00};
            end
            TAG_STS: etc_d = {TAG_STS, seq_d, sts_byte_q};
            default: etc_d = {TAG_IDLE, seq_d, 8'h00};
        endcase

        // New pulses set pending after the commit clear, so set wins.
        trk_pend_d = trk_eff_c || bus.track_valid;
        sts_pend_d = sts_eff_c || bus.status_req;
        if (bus.track_valid) begin
            trk_x_d = bus.track_x;
            trk_y_d = bus.track_y;
            if (trk_eff_c && (drop_q != DRP_MAX)) begin
                drop_d = drop_q + DRP_W'(1);
            end
        end
        if (bus.status_req) begin
            sts_byte_d = bus.status_byte;
        end

        // A received frame always beats the watchdog.
        if (bus.mosi_valid) begin
            motor_x_d   = bus.mosi_x;
            motor_y_d   = bus.mosi_y;
            motor_en_d  = bus.mosi_etc[16];
            motor_upd_d = 1'b1;
            timeout_d   = 1'b0;
            wd_d        = '0;
        end else begin
            if (wd_q != WD_MAX) begin
                wd_d = wd_q + WD_W'(1);
            end
            if (wd_d == WD_MAX) begin
                timeout_d  = 1'b1;
                motor_x_d  = X_CENTER;
                motor_y_d  = Y_CENTER;
                motor_en_d = 1'b0;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            trk_pend_q  <= 1'b0;
            trk_x_q     <= '0;
            trk_y_q     <= '0;
            sts_pend_q  <= 1'b0;
            sts_byte_q  <= '0;
            last_sts_q  <= 1'b1;
            seq_q       <= '0;
            sent_x_q    <= '0;
            sent_y_q    <= '0;
            drop_q      <= '0;
            enemy_x_q   <= '0;
            enemy_y_q   <= '0;
            etc_q       <= '0;
            motor_x_q   <= X_CENTER;
            motor_y_q   <= Y_CENTER;
            motor_en_q  <= 1'b0;
            motor_upd_q <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
        end else begin
            trk_pend_q  <= trk_pend_d;
            trk_x_q     <= trk_x_d;
            trk_y_q     <= trk_y_d;
            sts_pend_q  <= sts_pend_d;
            sts_byte_q  <= sts_byte_d;
            last_sts_q  <= last_sts_d;
            seq_q       <= seq_d;
            sent_x_q    <= sent_x_d;
            sent_y_q    <= sent_y_d;
            drop_q      <= drop_d;
            enemy_x_q   <= enemy_x_d;
            enemy_y_q   <= enemy_y_d;
            etc_q       <= etc_d;
            motor_x_q   <= motor_x_d;
            motor_y_q   <= motor_y_d;
            motor_en_q  <= motor_en_d;
            motor_upd_q <= motor_upd_d;
            timeout_q   <= timeout_d;
            wd_q        <= wd_d;
        end
    end

    assign bus.enemy_xdata  = enemy_x_q;
    assign bus.enemy_ydata  = enemy_y_q;
    assign bus.miso_etc     = etc_q;
    assign bus.motor_x      = motor_x_q;
    assign bus.motor_y      = motor_y_q;
    assign bus.motor_en     = motor_en_q;
    assign bus.motor_upd    = motor_upd_q;
    assign bus.link_timeout = timeout_q;
    assign bus.drop_cnt     = drop_q;

endmodule

// File: tb/tb_spi_link_ctrl.sv
// Bench for spi_link_ctrl: directed tables/sequences plus randomized traffic against a
// cycle-level reference model of the scheduling and watchdog rules.
module tb_spi_link_ctrl;
    localparam int unsigned TO = 100;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    spi_link_ctrl_if link ();

    spi_link_ctrl #(
        .TIMEOUT_CYC(TO),
        .X_CENTER   (8'd128),
        .Y_CENTER   (7'd64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (link)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic        m_tp, m_sp, m_last_sts;
    logic [9:0]  m_tx, m_sent_x, e_x;
    logic [8:0]  m_ty, m_sent_y, e_y;
    logic [7:0]  m_sb;
    logic [12:0] e_etc;
    int          m_seq, m_drop, m_idle;
    logic [7:0]  e_mx;
    logic [6:0]  e_my;
    logic        e_en, e_upd, e_to;

    typedef struct {
        logic [7:0]  mx;
        logic [6:0]  my;
        logic [16:0] etc;
        logic [7:0]  exp_mx;
        logic [6:0]  exp_my;
        logic        exp_en;
    } mvec_t;

    typedef struct {
        logic [9:0] tx;
        logic [8:0] ty;
        logic [9:0] exp_x;
        logic [8:0] exp_y;
    } tvec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rules applied in order: commit, stage from what is still pending, then new pulses.
    task automatic model_step();
        int pick;
        logic [1:0] tag;
        logic [7:0] pay;
        if (!reset) begin
            m_tp = 1'b0; m_sp = 1'b0; m_last_sts = 1'b1; m_seq = 0; m_drop = 0; m_idle = 0;
            m_tx = '0; m_ty = '0; m_sb = '0; m_sent_x = '0; m_sent_y = '0;
            e_x = '0; e_y = '0; e_etc = '0;
            e_mx = 8'd128; e_my = 7'd64; e_en = 1'b0; e_upd = 1'b0; e_to = 1'b0;
            return;
        end
        if (link.frame_req) begin
            if (e_etc[12:11] == 2'b01) begin
                m_tp = 1'b0; m_last_sts = 1'b0; m_sent_x = e_x; m_sent_y = e_y;
            end else if (e_etc[12:11] == 2'b10) begin
                m_sp = 1'b0; m_last_sts = 1'b1;
            end
            m_seq = (m_seq + 1) % 8;
        end
        if (m_tp && m_sp) pick = m_last_sts ? 1 : 2;
        else if (m_tp)    pick = 1;
        else if (m_sp)    pick = 2;
        else              pick = 0;
        case (pick)
            1:       begin e_x = m_tx;     e_y = m_ty;     tag = 2'b01; pay = 8'h00; end
            2:       begin e_x = m_sent_x; e_y = m_sent_y; tag = 2'b10; pay = m_sb;  end
            default: begin e_x = m_sent_x; e_y = m_sent_y; tag = 2'b00; pay = 8'h00; end
        endcase
        e_etc = {tag, 3'(m_seq), pay};
        if (link.track_valid) begin
            if (m_tp && m_drop < 255) m_drop++;
            m_tp = 1'b1; m_tx = link.track_x; m_ty = link.track_y;
        end
        if (link.status_req) begin
            m_sp = 1'b1; m_sb = link.status_byte;
        end
        e_upd = 1'b0;
        if (link.mosi_valid) begin
            e_mx = link.mosi_x; e_my = link.mosi_y; e_en = link.mosi_etc[16];
            e_upd = 1'b1; e_to = 1'b0; m_idle = 0;
        end else begin
            if (m_idle < int'(TO)) m_idle++;
            if (m_idle == int'(TO)) begin
                e_to = 1'b1; e_mx = 8'd128; e_my = 7'd64; e_en = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        chk("enemy_x",   32'(link.enemy_xdata),  32'(e_x));
        chk("enemy_y",   32'(link.enemy_ydata),  32'(e_y));
        chk("miso_etc",  32'(link.miso_etc),     32'(e_etc));
        chk("motor_x",   32'(link.motor_x),      32'(e_mx));
        chk("motor_y",   32'(link.motor_y),      32'(e_my));
        chk("motor_en",  32'(link.motor_en),     32'(e_en));
        chk("motor_upd", 32'(link.motor_upd),    32'(e_upd));
        chk("timeout",   32'(link.link_timeout), 32'(e_to));
        chk("drop_cnt",  32'(link.drop_cnt),     32'(m_drop));
    endtask

    // One clock: DUT and model see the same inputs, outputs checked 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        reset            = 1'b1;
        link.track_valid = 1'b0;
        link.status_req  = 1'b0;
        link.frame_req   = 1'b0;
        link.mosi_valid  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse_track(input logic [9:0] x, input logic [8:0] y);
        link.track_valid = 1'b1; link.track_x = x; link.track_y = y;
    endtask

    task automatic pulse_mosi(input logic [7:0] x, input logic [6:0] y, input logic [16:0] e);
        link.mosi_valid = 1'b1; link.mosi_x = x; link.mosi_y = y; link.mosi_etc = e;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ex"},  32'(link.enemy_xdata),  32'd0);
        chk({tag, "_ey"},  32'(link.enemy_ydata),  32'd0);
        chk({tag, "_etc"}, 32'(link.miso_etc),     32'd0);
        chk({tag, "_mx"},  32'(link.motor_x),      32'd128);
        chk({tag, "_my"},  32'(link.motor_y),      32'd64);
        chk({tag, "_en"},  32'(link.motor_en),     32'd0);
        chk({tag, "_upd"}, 32'(link.motor_upd),    32'd0);
        chk({tag, "_to"},  32'(link.link_timeout), 32'd0);
        chk({tag, "_drp"}, 32'(link.drop_cnt),     32'd0);
    endtask

    mvec_t mv[6];
    tvec_t tv[4];

    initial begin
        link.track_valid = 1'b0; link.track_x = '0; link.track_y = '0;
        link.status_req = 1'b0;  link.status_byte = '0; link.frame_req = 1'b0;
        link.mosi_valid = 1'b0;  link.mosi_x = '0; link.mosi_y = '0; link.mosi_etc = '0;

        mv[0] = '{8'd10,  7'd5,   17'h1_0000, 8'd10,  7'd5,   1'b1};
        mv[1] = '{8'd0,   7'd0,   17'h0_FFFF, 8'd0,   7'd0,   1'b0};
        mv[2] = '{8'd255, 7'd127, 17'h1_0000, 8'd255, 7'd127, 1'b1};
        mv[3] = '{8'd128, 7'd64,  17'h1_5A5A, 8'd128, 7'd64,  1'b1};
        mv[4] = '{8'h55,  7'h2A,  17'h0_0001, 8'h55,  7'h2A,  1'b0};
        mv[5] = '{8'hAA,  7'h55,  17'h1_FFFF, 8'hAA,  7'h55,  1'b1};

        tv[0] = '{10'd300,  9'd200, 10'd300,  9'd200};
        tv[1] = '{10'd0,    9'd0,   10'd0,    9'd0};
        tv[2] = '{10'd1023, 9'd511, 10'd1023, 9'd511};
        tv[3] = '{10'd512,  9'd256, 10'd512,  9'd256};

        // Reset state
        do_reset();
        tick();
        chk_reset_values("rst");

        // T1: single track frames, staged then committed
        for (int i = 0; i < 4; i++) begin
            pulse_track(tv[i].tx, tv[i].ty);
            tick();
            tick();
            chk("t1_stage_x", 32'(link.enemy_xdata), 32'(tv[i].exp_x));
            chk("t1_stage_y", 32'(link.enemy_ydata), 32'(tv[i].exp_y));
            chk("t1_stage_etc", 32'(link.miso_etc), 32'({2'b01, 3'(i), 8'h00}));
            link.frame_req = 1'b1;
            tick();
            chk("t1_commit_etc", 32'(link.miso_etc), 32'({2'b00, 3'(i + 1), 8'h00}));
            chk("t1_hold_x", 32'(link.enemy_xdata), 32'(tv[i].exp_x));
            chk("t1_hold_y", 32'(link.enemy_ydata), 32'(tv[i].exp_y));
        end

        // T2: round-robin between track and status
        do_reset();
        link.status_byte = 8'hA5; link.status_req = 1'b1;
        pulse_track(10'd7, 9'd3);
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_tag", 32'(link.miso_etc[12:11]), (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("t2_payload", 32'(link.miso_etc[7:0]), (i % 2 == 0) ? 32'h00 : 32'hA5);
            link.frame_req = 1'b1;
            link.status_req = 1'b1;
            pulse_track(10'(100 + i), 9'(50 + i));
            tick();
            tick();
        end

        // T3: overwrite counting and saturation
        do_reset();
        pulse_track(10'd10, 9'd1); tick();
        pulse_track(10'd20, 9'd2); tick();
        pulse_track(10'd30, 9'd3); tick();
        tick();
        chk("t3_drop2", 32'(link.drop_cnt), 32'd2);
        chk("t3_newest_x", 32'(link.enemy_xdata), 32'd30);
        for (int i = 0; i < 300; i++) begin
            pulse_track(10'(i), 9'(i));
            tick();
        end
        chk("t3_drop_sat", 32'(link.drop_cnt), 32'd255);

        // T4: new track sample in the commit cycle survives
        do_reset();
        pulse_track(10'd5, 9'd6); tick();
        tick();
        chk("t4_first_x", 32'(link.enemy_xdata), 32'd5);
        link.frame_req = 1'b1;
        pulse_track(10'd7, 9'd8);
        tick();
        chk("t4_after_commit_tag", 32'(link.miso_etc[12:11]), 32'd0);
        chk("t4_drop", 32'(link.drop_cnt), 32'd0);
        tick();
        chk("t4_second_x", 32'(link.enemy_xdata), 32'd7);
        chk("t4_second_y", 32'(link.enemy_ydata), 32'd8);
        chk("t4_second_tag", 32'(link.miso_etc[12:11]), 32'd1);

        // T5: motor loads from a vector table, then watchdog boundaries
        for (int i = 0; i < 6; i++) begin
            pulse_mosi(mv[i].mx, mv[i].my, mv[i].etc);
            tick();
            chk("t5_mx", 32'(link.motor_x), 32'(mv[i].exp_mx));
            chk("t5_my", 32'(link.motor_y), 32'(mv[i].exp_my));
            chk("t5_en", 32'(link.motor_en), 32'(mv[i].exp_en));
            chk("t5_upd_hi", 32'(link.motor_upd), 32'd1);
            tick();
            chk("t5_upd_lo", 32'(link.motor_upd), 32'd0);
        end
        pulse_mosi(8'd10, 7'd5, 17'h1_0000);
        tick();
        for (int i = 0; i < 99; i++) tick();
        pulse_mosi(8'd11, 7'd6, 17'h1_0000);
        tick();
        chk("t5_valid_wins_to", 32'(link.link_timeout), 32'd0);
        chk("t5_valid_wins_mx", 32'(link.motor_x), 32'd11);
        for (int i = 0; i < 99; i++) tick();
        chk("t5_before_to", 32'(link.link_timeout), 32'd0);
        tick();
        chk("t5_to", 32'(link.link_timeout), 32'd1);
        chk("t5_to_mx", 32'(link.motor_x), 32'd128);
        chk("t5_to_my", 32'(link.motor_y), 32'd64);
        chk("t5_to_en", 32'(link.motor_en), 32'd0);
        pulse_mosi(8'd3, 7'd2, 17'h1_0000);
        tick();
        chk("t5_clear_to", 32'(link.link_timeout), 32'd0);
        chk("t5_clear_mx", 32'(link.motor_x), 32'd3);
        chk("t5_clear_en", 32'(link.motor_en), 32'd1);

        // T6: reset while data pending and link timed out
        for (int i = 0; i < 100; i++) tick();
        link.status_req = 1'b1;
        pulse_track(10'd44, 9'd33);
        tick();
        tick();
        do_reset();
        chk_reset_values("t6");
        link.frame_req = 1'b1;
        tick();
        chk("t6_idle_etc", 32'(link.miso_etc), 32'h100);
        chk("t6_idle_x", 32'(link.enemy_xdata), 32'd0);

        // Randomized traffic with quiet stretches long enough to trip the watchdog
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) pulse_track(10'($urandom), 9'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                link.status_req = 1'b1; link.status_byte = 8'($urandom);
            end
            if ($urandom_range(0, 5) == 0) link.frame_req = 1'b1;
            if (((c / 400) % 2 == 0) && ($urandom_range(0, 9) == 0))
                pulse_mosi(8'($urandom), 7'($urandom), 17'($urandom));
            if ($urandom_range(0, 699) == 0) reset = 1'b0;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
